// File: rtl/score_window_sequencer_pkg.sv
// Shared note codes, minimum beat period and FSM state encoding for the
// score window sequencer.
package score_pkg;

    localparam logic [3:0] REST_NOTE  = 4'b0001;
    localparam logic [3:0] END_NOTE   = 4'b1111;
    localparam int         MIN_PERIOD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FETCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

endpackage

// File: rtl/score_window_sequencer_beat_timer.sv
// Beat period counter: counts enabled clocks and ticks on the last clock of
// each period. The count is exported only when SCORE_DEBUG_EN is defined.
module beat_timer #(
    parameter int TEMPO_W = 26
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [TEMPO_W-1:0] period,
    output logic               tick
`ifdef SCORE_DEBUG_EN
    ,
    output logic [TEMPO_W-1:0] count
`endif
);

    logic [TEMPO_W-1:0] cnt_q;
    logic [TEMPO_W-1:0] cnt_d;
    logic               tick_s;

    // Next count; clear wins over counting, a tick restarts the period
    always_comb begin
        tick_s = 1'b0;
        cnt_d  = cnt_q;
        if (clear) begin
            cnt_d = {TEMPO_W{1'b0}};
        end else if (enable) begin
            if (cnt_q == period - TEMPO_W'(1)) begin
                cnt_d  = {TEMPO_W{1'b0}};
                tick_s = 1'b1;
            end else begin
                cnt_d = cnt_q + TEMPO_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= {TEMPO_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = tick_s;
`ifdef SCORE_DEBUG_EN
    assign count = cnt_q;
`endif

endmodule

// File: rtl/score_window_sequencer.sv
// Plays a song from a score ROM into a DEPTH-note look-ahead window, one note
// per beat. Defining SCORE_DEBUG_EN adds the 64-bit debug_out port.
module score_window_sequencer
    import score_pkg::*;
#(
    parameter int NOTE_W  = 4,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 7,
    parameter int SONG_W  = 2,
    parameter int TEMPO_W = 26
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SONG_W-1:0]       song_sel,
    input  logic [TEMPO_W-1:0]      tempo_period,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    loop_en,
    output logic [SONG_W-1:0]       rom_song,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W-1:0]       rom_data,
    output logic [DEPTH*NOTE_W-1:0] window_out,
    output logic                    beat,
    output logic                    playing,
    output logic                    song_done
`ifdef SCORE_DEBUG_EN
    ,
    output logic [63:0]             debug_out
`endif
);

    localparam int WIN_W = DEPTH * NOTE_W;
    localparam int DC_W  = $clog2(DEPTH + 1);
    localparam logic [NOTE_W-1:0] REST_N = NOTE_W'(REST_NOTE);
    localparam logic [NOTE_W-1:0] END_N  = {NOTE_W{END_NOTE[0]}};

    state_e             state_q,   state_d;
    logic [SONG_W-1:0]  song_q,    song_d;
    logic [TEMPO_W-1:0] period_q,  period_d;
    logic [ADDR_W-1:0]  addr_q,    addr_d;
    logic [WIN_W-1:0]   window_q,  window_d;
    logic [DC_W-1:0]    drain_q,   drain_d;
    logic               beat_q,    beat_d;
    logic               playing_q, playing_d;
    logic               done_q,    done_d;
    logic               tick_s;
    logic               timer_en_s;
    logic               end_s;

    function automatic logic [WIN_W-1:0] shift_in(input logic [WIN_W-1:0] win,
                                                  input logic [NOTE_W-1:0] note);
        return {note, win[WIN_W-1:NOTE_W]};
    endfunction

    // The counter keeps running through FETCH/SHIFT so beats stay evenly spaced
    assign timer_en_s = (state_q != ST_IDLE) && !pause;
    assign end_s      = (rom_data == END_N) || (addr_q == {ADDR_W{1'b1}});

`ifdef SCORE_DEBUG_EN
    logic [TEMPO_W-1:0] cnt_dbg_s;
`endif

    beat_timer #(.TEMPO_W(TEMPO_W)) u_beat_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start),
        .enable  (timer_en_s),
        .period  (period_q),
        .tick    (tick_s)
`ifdef SCORE_DEBUG_EN
        ,
        .count   (cnt_dbg_s)
`endif
    );

    // Next-state and datapath decode; start overrides everything but reset
    always_comb begin
        state_d  = state_q;
        song_d   = song_q;
        period_d = period_q;
        addr_d   = addr_q;
        window_d = window_q;
        drain_d  = drain_q;
        beat_d   = 1'b0;
        done_d   = 1'b0;
        if (start) begin
            state_d  = ST_RUN;
            song_d   = song_sel;
            period_d = (tempo_period < TEMPO_W'(MIN_PERIOD)) ? TEMPO_W'(MIN_PERIOD)
                                                             : tempo_period;
            addr_d   = {ADDR_W{1'b0}};
            window_d = {DEPTH{REST_N}};
            drain_d  = {DC_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (tick_s) begin
                        beat_d  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    state_d = ST_RUN;
                    if (end_s) begin
                        window_d = shift_in(window_q, REST_N);
                        if (loop_en) begin
                            addr_d = {ADDR_W{1'b0}};
                        end else begin
                            state_d = ST_DRAIN;
                            drain_d = {DC_W{1'b0}};
                        end
                    end else begin
                        window_d = shift_in(window_q, rom_data);
                        addr_d   = addr_q + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (tick_s) begin
                        beat_d   = 1'b1;
                        window_d = shift_in(window_q, REST_N);
                        if (drain_q == DC_W'(DEPTH - 1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                            drain_d = {DC_W{1'b0}};
                        end else begin
                            drain_d = drain_q + DC_W'(1);
                        end
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        playing_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            song_q    <= {SONG_W{1'b0}};
            period_q  <= TEMPO_W'(MIN_PERIOD);
            addr_q    <= {ADDR_W{1'b0}};
            window_q  <= {DEPTH{REST_N}};
            drain_q   <= {DC_W{1'b0}};
            beat_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            song_q    <= song_d;
            period_q  <= period_d;
            addr_q    <= addr_d;
            window_q  <= window_d;
            drain_q   <= drain_d;
            beat_q    <= beat_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign rom_song   = song_q;
    assign rom_addr   = addr_q;
    assign window_out = window_q;
    assign beat       = beat_q;
    assign playing    = playing_q;
    assign song_done  = done_q;

`ifdef SCORE_DEBUG_EN
    assign debug_out = {{1'b0, state_q}, 12'(addr_q), 32'(cnt_dbg_s),
                        16'(window_q[WIN_W-1 -: NOTE_W])};
`endif

endmodule

// File: tb/tb_score_window_sequencer.sv
// Randomised and directed bench for score_window_sequencer against a
// beat-level behavioural model with a synchronous score ROM.
module tb_score_window_sequencer;

    localparam int NOTE_W  = 4;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 7;
    localparam int SONG_W  = 2;
    localparam int TEMPO_W = 26;
    localparam int NADDR   = 128;
    localparam logic [3:0] REST = 4'd1;
    localparam logic [3:0] ENDN = 4'd15;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [SONG_W-1:0]       song_sel;
    logic [TEMPO_W-1:0]      tempo_period;
    logic                    start;
    logic                    pause;
    logic                    loop_en;
    logic [SONG_W-1:0]       rom_song;
    logic [ADDR_W-1:0]       rom_addr;
    logic [NOTE_W-1:0]       rom_data;
    logic [DEPTH*NOTE_W-1:0] window_out;
    logic                    beat;
    logic                    playing;
    logic                    song_done;

    score_window_sequencer #(
        .NOTE_W(NOTE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SONG_W(SONG_W), .TEMPO_W(TEMPO_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .song_sel(song_sel), .tempo_period(tempo_period),
        .start(start), .pause(pause), .loop_en(loop_en), .rom_song(rom_song),
        .rom_addr(rom_addr), .rom_data(rom_data), .window_out(window_out),
        .beat(beat), .playing(playing), .song_done(song_done)
    );

    always #5 clk = ~clk;

    logic [3:0] rom_mem [4][NADDR];
    always @(posedge clk) rom_data <= rom_mem[rom_song][rom_addr];

    // behavioural model state
    bit         m_play, m_drain, m_beat, m_done;
    int         m_drain_left, m_song, m_period, m_addr, m_act, m_pend;
    logic [3:0] m_win [DEPTH];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [63:0] pack_win();
        logic [63:0] v;
        for (int i = 0; i < DEPTH; i++) v[i*4 +: 4] = m_win[i];
        return v;
    endfunction

    task automatic push(input logic [3:0] note);
        for (int i = 0; i < DEPTH - 1; i++) m_win[i] = m_win[i+1];
        m_win[DEPTH-1] = note;
    endtask

    task automatic all_rest();
        for (int i = 0; i < DEPTH; i++) m_win[i] = REST;
    endtask

    // The note fetched for a beat lands in the window two clocks after it
    task automatic apply_fetch();
        logic [3:0] note;
        note = rom_mem[m_song][m_addr];
        if (note == ENDN || m_addr == NADDR - 1) begin
            push(REST);
            if (loop_en) m_addr = 0;
            else begin
                m_drain      = 1'b1;
                m_drain_left = DEPTH;
            end
        end else begin
            push(note);
            m_addr++;
        end
    endtask

    task automatic model_edge();
        m_beat = 1'b0;
        m_done = 1'b0;
        if (!reset_n) begin
            m_play = 1'b0; m_drain = 1'b0; m_song = 0; m_addr = 0; m_act = 0; m_pend = 0;
            all_rest();
        end else if (start) begin
            m_play = 1'b1; m_drain = 1'b0; m_song = int'(song_sel); m_addr = 0;
            m_act = 0; m_pend = 0;
            m_period = (tempo_period < 4) ? 4 : int'(tempo_period);
            all_rest();
        end else if (m_play) begin
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) apply_fetch();
            end
            if (!pause) begin
                m_act++;
                if (m_act == m_period) begin
                    m_act  = 0;
                    m_beat = 1'b1;
                    if (m_drain) begin
                        push(REST);
                        m_drain_left--;
                        if (m_drain_left == 0) begin
                            m_play  = 1'b0;
                            m_drain = 1'b0;
                            m_done  = 1'b1;
                        end
                    end else begin
                        m_pend = 2;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_eq("beat",      64'(beat),       64'(m_beat));
        check_eq("song_done", 64'(song_done),  64'(m_done));
        check_eq("playing",   64'(playing),    64'(m_play));
        check_eq("rom_addr",  64'(rom_addr),   64'(m_addr));
        check_eq("rom_song",  64'(rom_song),   64'(m_song));
        check_eq("window",    64'(window_out), pack_win());
    endtask

    task automatic do_start(input int song, input int tempo, input bit lp);
        song_sel     = SONG_W'(song);
        tempo_period = TEMPO_W'(tempo);
        loop_en      = lp;
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    task automatic wait_beat(input int max_cyc, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < max_cyc) begin
            step();
            n++;
            if (beat) seen = 1'b1;
        end
        check_eq("beat_seen", 64'(seen), 64'd1);
    endtask

    task automatic run_to_done(input int max_cyc, output int beats_at_done);
        int beats;
        beats = 0;
        beats_at_done = 0;
        for (int i = 0; i < max_cyc && beats_at_done == 0; i++) begin
            step();
            if (beat) beats++;
            if (song_done) beats_at_done = beats;
        end
    endtask

    initial begin
        int n;
        int done_at;
        for (int a = 0; a < NADDR; a++) begin
            rom_mem[0][a] = 4'($urandom_range(0, 14));
            rom_mem[1][a] = 4'($urandom_range(0, 14));
            rom_mem[2][a] = 4'($urandom_range(0, 14));
            rom_mem[3][a] = 4'($urandom_range(0, 14));
        end
        rom_mem[0][20] = ENDN;
        rom_mem[1][0] = 4'd2; rom_mem[1][1] = 4'd3; rom_mem[1][2] = 4'd4; rom_mem[1][3] = ENDN;
        rom_mem[2][0] = 4'd5; rom_mem[2][1] = 4'd6; rom_mem[2][2] = 4'd7;
        rom_mem[2][3] = 4'd8; rom_mem[2][4] = 4'd9; rom_mem[2][5] = ENDN;

        reset_n = 1'b0; start = 1'b0; pause = 1'b0; loop_en = 1'b0;
        song_sel = '0; tempo_period = 26'd10;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // notes 2,3,4 then END without looping: done on beat 20
        do_start(1, 10, 1'b0);
        run_to_done(400, done_at);
        check_eq("done_on_beat", 64'(done_at), 64'd20);
        repeat (5) step();

        // looping song wraps back to address 0
        do_start(1, 6, 1'b1);
        repeat (6 * 12) step();

        // pause for 25 clocks in the middle of a beat
        do_start(0, 10, 1'b0);
        wait_beat(50, n);
        repeat (4) step();
        pause = 1'b1;
        repeat (25) step();
        pause = 1'b0;
        wait_beat(100, n);
        check_eq("pause_delay", 64'(n + 4 + 25), 64'd35);

        // periods below the minimum run at 4 clocks per beat
        do_start(2, 1, 1'b0);
        wait_beat(20, n);
        check_eq("min_period_first", 64'(n), 64'd4);
        wait_beat(20, n);
        check_eq("min_period_next", 64'(n), 64'd4);
        do_start(2, 0, 1'b0);
        wait_beat(20, n);
        check_eq("zero_period", 64'(n), 64'd4);

        // restart while draining, switching to song 2
        do_start(1, 5, 1'b0);
        repeat (5 * 7) step();
        check_eq("in_drain_addr", 64'(rom_addr), 64'd3);
        do_start(2, 7, 1'b0);
        check_eq("restart_song", 64'(rom_song), 64'd2);
        repeat (7 * 8) step();

        // a song with no end marker ends at the last address
        do_start(3, 4, 1'b0);
        run_to_done(700, done_at);
        check_eq("wrap_done_beat", 64'(done_at), 64'd144);

        // reset while SHIFT is in progress
        do_start(2, 8, 1'b0);
        wait_beat(20, n);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_eq("reset_playing", 64'(playing), 64'd0);
        step();

        // randomised play with pauses, loop toggles and restarts
        for (int r = 0; r < 6; r++) begin
            do_start(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 400; c++) begin
                pause        = ($urandom_range(0, 99) < 10);
                song_sel     = SONG_W'($urandom_range(0, 3));
                tempo_period = TEMPO_W'($urandom_range(0, 12));
                if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
                start        = ($urandom_range(0, 199) == 0);
                step();
            end
            start = 1'b0;
            pause = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
